// File: rtl/known_ch_table_pkg.sv
// Shared types and constants for the known cluster-head table.
package knownch_pkg;

    localparam int WORD_WIDTH = 16;

    localparam logic [WORD_WIDTH-1:0] HOPS_NONE = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        WRITE,
        SCAN,
        COMMIT
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [WORD_WIDTH-1:0] id;
        logic [WORD_WIDTH-1:0] hops;
        logic [WORD_WIDTH-1:0] qvalue;
    } ch_entry_t;

endpackage

// File: rtl/known_ch_table_if.sv
// Strobe/result bundle between the routing logic and the known-CH table.
interface known_ch_table_if #(
    parameter int WORD_WIDTH = knownch_pkg::WORD_WIDTH,
    parameter int DEPTH      = 4,
    parameter int IDX_W      = $clog2(DEPTH)
);
    logic                  HB_reset;
    logic [WORD_WIDTH-1:0] HB_CHlimit;
    logic                  en_KCH;
    logic [WORD_WIDTH-1:0] fCH_ID;
    logic [WORD_WIDTH-1:0] fCH_Hops;
    logic [WORD_WIDTH-1:0] fCH_QValue;
    logic                  en_drop;
    logic [WORD_WIDTH-1:0] drop_ID;
    logic [WORD_WIDTH-1:0] chosenCH;
    logic [WORD_WIDTH-1:0] hopsFromCH;
    logic [WORD_WIDTH-1:0] chosenQValue;
    logic                  ch_valid;
    logic [IDX_W:0]        ch_count;
    logic                  table_full;
    logic                  busy;

    modport master (
        output HB_reset, HB_CHlimit, en_KCH, fCH_ID, fCH_Hops, fCH_QValue, en_drop, drop_ID,
        input  chosenCH, hopsFromCH, chosenQValue, ch_valid, ch_count, table_full, busy
    );

    modport slave (
        input  HB_reset, HB_CHlimit, en_KCH, fCH_ID, fCH_Hops, fCH_QValue, en_drop, drop_ID,
        output chosenCH, hopsFromCH, chosenQValue, ch_valid, ch_count, table_full, busy
    );
endinterface

// File: rtl/known_ch_table_compare.sv
// Ranking of two table entries: higher Q, then fewer hops, then lower ID; invalid never wins.
module ch_compare
    import knownch_pkg::*;
(
    input  ch_entry_t a,
    input  ch_entry_t b,
    output logic      a_better
);
    always_comb begin
        a_better = 1'b0;
        if (a.valid && !b.valid) begin
            a_better = 1'b1;
        end else if (a.valid && b.valid) begin
            if (a.qvalue != b.qvalue)  a_better = (a.qvalue > b.qvalue);
            else if (a.hops != b.hops) a_better = (a.hops < b.hops);
            else                       a_better = (a.id < b.id);
        end
    end
endmodule

// File: rtl/known_ch_table.sv
// Table of known cluster heads with sequential search/update/rescan and atomic best-CH publish.
module known_ch_table #(
    parameter int WORD_WIDTH = knownch_pkg::WORD_WIDTH,
    parameter int DEPTH      = 4,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input logic             clk,
    input logic             nrst,
    known_ch_table_if.slave bus
);
    import knownch_pkg::*;

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W:0]        DEPTH_C  = (IDX_W + 1)'(DEPTH);
    localparam logic [WORD_WIDTH-1:0] DEPTH_W  = WORD_WIDTH'(DEPTH);

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      idx, match_idx, free_idx, worst_idx, best_idx;
    logic                  match_found, free_found, worst_found, best_found, op_drop, last;
    logic [IDX_W:0]        count, limit, count_r;
    logic [DEPTH-1:0]      valid_q;
    logic [WORD_WIDTH-1:0] tbl_id   [DEPTH];
    logic [WORD_WIDTH-1:0] tbl_hops [DEPTH];
    logic [WORD_WIDTH-1:0] tbl_q    [DEPTH];
    logic [WORD_WIDTH-1:0] new_id, new_hops, new_q;
    logic [WORD_WIDTH-1:0] chosen_r, hops_r, qv_r;
    logic                  valid_r, w_better, b_better;
    ch_entry_t             cur_e, worst_e, best_e, new_e, cmp_a, cmp_b;

    function automatic logic [IDX_W:0] eff_limit(input logic [WORD_WIDTH-1:0] l);
        if (l == '0 || l > DEPTH_W) return DEPTH_C;
        return l[IDX_W:0];
    endfunction

    assign last = (idx == LAST_IDX);

    always_comb begin
        cur_e   = '{valid: valid_q[idx], id: tbl_id[idx], hops: tbl_hops[idx], qvalue: tbl_q[idx]};
        worst_e = '{valid: valid_q[worst_idx], id: tbl_id[worst_idx],
                    hops: tbl_hops[worst_idx], qvalue: tbl_q[worst_idx]};
        best_e  = '{valid: valid_q[best_idx], id: tbl_id[best_idx],
                    hops: tbl_hops[best_idx], qvalue: tbl_q[best_idx]};
        new_e   = '{valid: 1'b1, id: new_id, hops: new_hops, qvalue: new_q};
        // One comparator serves both worst-tracking in SEARCH and the replace test in WRITE.
        if (state == WRITE) begin
            cmp_a = new_e;
            cmp_b = worst_e;
        end else begin
            cmp_a = worst_e;
            cmp_b = cur_e;
        end
    end

    ch_compare u_cmp_worst (.a(cmp_a), .b(cmp_b),  .a_better(w_better));
    ch_compare u_cmp_best  (.a(cur_e), .b(best_e), .a_better(b_better));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.en_KCH || bus.en_drop) state_nxt = SEARCH;
            SEARCH:  if (last) state_nxt = WRITE;
            WRITE:   state_nxt = SCAN;
            SCAN:    if (last) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.HB_reset) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (nrst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (nrst || bus.HB_reset) begin
            limit       <= nrst ? DEPTH_C : eff_limit(bus.HB_CHlimit);
            count       <= '0;
            valid_q     <= '0;
            idx         <= '0;
            op_drop     <= 1'b0;
            {match_found, free_found, worst_found, best_found} <= '0;
            {match_idx, free_idx, worst_idx, best_idx}         <= '0;
            chosen_r    <= '0;
            hops_r      <= HOPS_NONE;
            qv_r        <= '0;
            valid_r     <= 1'b0;
            count_r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    idx <= '0;
                    {match_found, free_found, worst_found, best_found} <= '0;
                    op_drop <= !bus.en_KCH;
                end
                SEARCH: begin
                    idx <= last ? '0 : idx + 1'b1;
                    if (cur_e.valid && cur_e.id == new_id) begin
                        match_found <= 1'b1;
                        match_idx   <= idx;
                    end
                    if (!cur_e.valid && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= idx;
                    end
                    if (cur_e.valid && (!worst_found || w_better)) begin
                        worst_found <= 1'b1;
                        worst_idx   <= idx;
                    end
                end
                WRITE: begin
                    if (op_drop) begin
                        if (match_found) begin
                            valid_q[match_idx] <= 1'b0;
                            count              <= count - 1'b1;
                        end
                    end else if (!match_found && count < limit) begin
                        valid_q[free_idx] <= 1'b1;
                        count             <= count + 1'b1;
                    end
                end
                SCAN: begin
                    idx <= last ? '0 : idx + 1'b1;
                    if (cur_e.valid && (!best_found || b_better)) begin
                        best_found <= 1'b1;
                        best_idx   <= idx;
                    end
                end
                COMMIT: begin
                    valid_r  <= best_found;
                    chosen_r <= best_found ? best_e.id     : '0;
                    hops_r   <= best_found ? best_e.hops   : HOPS_NONE;
                    qv_r     <= best_found ? best_e.qvalue : '0;
                    count_r  <= count;
                end
                default: ;
            endcase
        end
    end

    // Entry payload carries no reset; the valid bits alone define table contents.
    always_ff @(posedge clk) begin
        if (state == IDLE && (bus.en_KCH || bus.en_drop)) begin
            new_id   <= bus.en_KCH ? bus.fCH_ID : bus.drop_ID;
            new_hops <= bus.fCH_Hops;
            new_q    <= bus.fCH_QValue;
        end
        if (state == WRITE && !op_drop) begin
            if (match_found) begin
                tbl_hops[match_idx] <= new_hops;
                tbl_q[match_idx]    <= new_q;
            end else if (count < limit) begin
                tbl_id[free_idx]   <= new_id;
                tbl_hops[free_idx] <= new_hops;
                tbl_q[free_idx]    <= new_q;
            end else if (w_better) begin
                tbl_id[worst_idx]   <= new_id;
                tbl_hops[worst_idx] <= new_hops;
                tbl_q[worst_idx]    <= new_q;
            end
        end
    end

    assign bus.chosenCH     = chosen_r;
    assign bus.hopsFromCH   = hops_r;
    assign bus.chosenQValue = qv_r;
    assign bus.ch_valid     = valid_r;
    assign bus.ch_count     = count_r;
    assign bus.table_full   = (count_r == limit);
    assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_known_ch_table.sv
// Bench for known_ch_table: set-based reference model, per-cycle output check, directed and random ops.
module tb_known_ch_table;
    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LAT   = 2 * DEPTH + 2;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    known_ch_table_if #(.WORD_WIDTH(W), .DEPTH(DEPTH), .IDX_W(IDX_W)) bus ();
    known_ch_table #(.WORD_WIDTH(W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .nrst(nrst), .bus(bus)
    );

    typedef struct {
        logic [W-1:0] id;
        logic [W-1:0] hops;
        logic [W-1:0] q;
    } ent_t;

    ent_t         tbl[$];
    int           m_limit, m_busy, total, bad;
    bit           started;
    logic [W-1:0] e_chosen, e_hops, e_q;
    logic         e_valid;
    int           e_count;

    // Larger key ranks better: high Q, then low hops, then low ID.
    function automatic logic [3*W-1:0] key(input ent_t e);
        return {e.q, ~e.hops, ~e.id};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic publish();
        int bi;
        e_count = tbl.size();
        if (tbl.size() == 0) begin
            e_valid = 1'b0; e_chosen = '0; e_hops = 16'hFFFF; e_q = '0;
        end else begin
            bi = 0;
            foreach (tbl[i]) if (key(tbl[i]) > key(tbl[bi])) bi = i;
            e_valid = 1'b1; e_chosen = tbl[bi].id; e_hops = tbl[bi].hops; e_q = tbl[bi].q;
        end
    endtask

    task automatic m_insert(input logic [W-1:0] id, input logic [W-1:0] h, input logic [W-1:0] q);
        int   mi, wi;
        ent_t e;
        e = '{id: id, hops: h, q: q};
        mi = -1;
        foreach (tbl[i]) if (tbl[i].id == id) mi = i;
        if (mi >= 0) begin
            tbl[mi].hops = h;
            tbl[mi].q    = q;
        end else if (tbl.size() < m_limit) begin
            tbl.push_back(e);
        end else begin
            wi = 0;
            foreach (tbl[i]) if (key(tbl[i]) < key(tbl[wi])) wi = i;
            if (key(e) > key(tbl[wi])) tbl[wi] = e;
        end
    endtask

    task automatic m_drop(input logic [W-1:0] id);
        for (int i = 0; i < tbl.size(); i++)
            if (tbl[i].id == id) begin
                tbl.delete(i);
                break;
            end
    endtask

    always @(posedge clk) begin
        if (nrst) begin
            tbl.delete(); m_limit = DEPTH; m_busy = 0; publish(); started = 1'b1;
        end else if (started) begin
            if (bus.HB_reset) begin
                tbl.delete();
                m_limit = (bus.HB_CHlimit == 0 || bus.HB_CHlimit > DEPTH) ? DEPTH : int'(bus.HB_CHlimit);
                m_busy = 0;
                publish();
            end else if (m_busy == 0 && bus.en_KCH) begin
                m_insert(bus.fCH_ID, bus.fCH_Hops, bus.fCH_QValue);
                m_busy = LAT;
            end else if (m_busy == 0 && bus.en_drop) begin
                m_drop(bus.drop_ID);
                m_busy = LAT;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) publish();
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cyc_busy",   32'(bus.busy),         32'(m_busy != 0));
            chk("cyc_valid",  32'(bus.ch_valid),     32'(e_valid));
            chk("cyc_chosen", 32'(bus.chosenCH),     32'(e_chosen));
            chk("cyc_hops",   32'(bus.hopsFromCH),   32'(e_hops));
            chk("cyc_q",      32'(bus.chosenQValue), 32'(e_q));
            chk("cyc_count",  32'(bus.ch_count),     32'(e_count));
            chk("cyc_full",   32'(bus.table_full),   32'(e_count == m_limit));
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy=%0b want 0", bus.busy);
        end
    endtask

    task automatic ins(input logic [W-1:0] id, input logic [W-1:0] h, input logic [W-1:0] q);
        @(negedge clk);
        bus.fCH_ID = id; bus.fCH_Hops = h; bus.fCH_QValue = q; bus.en_KCH = 1'b1;
        @(negedge clk);
        bus.en_KCH = 1'b0;
        wait_idle();
    endtask

    task automatic drop(input logic [W-1:0] id);
        @(negedge clk);
        bus.drop_ID = id; bus.en_drop = 1'b1;
        @(negedge clk);
        bus.en_drop = 1'b0;
        wait_idle();
    endtask

    task automatic hb(input logic [W-1:0] lim);
        @(negedge clk);
        bus.HB_reset = 1'b1; bus.HB_CHlimit = lim;
        @(negedge clk);
        bus.HB_reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t exceeded", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] qv;
        int r;
        total = 0; bad = 0; started = 1'b0;
        nrst = 1'b1;
        bus.HB_reset = 0; bus.HB_CHlimit = 0; bus.en_KCH = 0; bus.en_drop = 0;
        bus.fCH_ID = 0; bus.fCH_Hops = 0; bus.fCH_QValue = 0; bus.drop_ID = 0;
        @(negedge clk);
        nrst = 1'b0;
        chk("rst_chosen", 32'(bus.chosenCH), 0);
        chk("rst_hops",   32'(bus.hopsFromCH), 32'hFFFF);
        chk("rst_valid",  32'(bus.ch_valid), 0);
        chk("rst_busy",   32'(bus.busy), 0);

        ins(23, 2, 16'h3000); chk("ins23_chosen", 32'(bus.chosenCH), 23); chk("ins23_hops", 32'(bus.hopsFromCH), 2);
        ins(45, 2, 16'h2000); chk("ins45_chosen", 32'(bus.chosenCH), 23);
        ins(12, 1, 16'h4000); chk("ins12_chosen", 32'(bus.chosenCH), 12);
        ins(6, 1, 16'h4000);  chk("ins6_tie",     32'(bus.chosenCH), 6);
        ins(65, 1, 16'h6000);
        chk("ins65_chosen", 32'(bus.chosenCH), 65);
        chk("ins65_count",  32'(bus.ch_count), 4);
        chk("ins65_full",   32'(bus.table_full), 1);

        ins(65, 1, 16'h1000);
        chk("ref_count",  32'(bus.ch_count), 4);
        chk("ref_chosen", 32'(bus.chosenCH), 6);
        chk("ref_hops",   32'(bus.hopsFromCH), 1);
        chk("ref_q",      32'(bus.chosenQValue), 32'h4000);

        hb(2);
        ins(1, 3, 16'h1000);
        ins(2, 3, 16'h2000); chk("lim_full", 32'(bus.table_full), 1);
        ins(3, 3, 16'h1800);
        ins(4, 3, 16'h0800);
        chk("lim_chosen", 32'(bus.chosenCH), 2);
        chk("lim_count",  32'(bus.ch_count), 2);

        drop(2); chk("drop2_chosen", 32'(bus.chosenCH), 3); chk("drop2_count", 32'(bus.ch_count), 1);
        drop(3); chk("drop3_valid",  32'(bus.ch_valid), 0); chk("drop3_hops", 32'(bus.hopsFromCH), 32'hFFFF);
        drop(9); chk("drop9_count",  32'(bus.ch_count), 0); chk("drop9_valid", 32'(bus.ch_valid), 0);

        @(negedge clk);
        bus.fCH_ID = 50; bus.fCH_Hops = 1; bus.fCH_QValue = 16'h7000; bus.en_KCH = 1'b1;
        @(posedge clk);
        #1 bus.en_KCH = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk);
            #1;
            chk("lat_busy", 32'(bus.busy), 32'(k < LAT));
            if (k < LAT) chk("lat_hold", 32'(bus.ch_valid), 0);
            else         chk("lat_chosen", 32'(bus.chosenCH), 50);
        end

        @(negedge clk);
        bus.fCH_ID = 60; bus.fCH_Hops = 1; bus.fCH_QValue = 16'h7800; bus.en_KCH = 1'b1;
        @(negedge clk);
        bus.en_KCH = 1'b0;
        repeat (6) @(negedge clk);
        hb(0);
        chk("hbscan_chosen", 32'(bus.chosenCH), 0);
        chk("hbscan_hops",   32'(bus.hopsFromCH), 32'hFFFF);
        chk("hbscan_valid",  32'(bus.ch_valid), 0);
        chk("hbscan_busy",   32'(bus.busy), 0);

        @(negedge clk);
        bus.fCH_ID = 70; bus.fCH_Hops = 2; bus.fCH_QValue = 16'h3000; bus.en_KCH = 1'b1;
        @(negedge clk);
        bus.en_KCH = 1'b0;
        repeat (2) @(negedge clk);
        bus.fCH_ID = 71; bus.fCH_Hops = 0; bus.fCH_QValue = 16'hFFFF; bus.en_KCH = 1'b1;
        @(negedge clk);
        bus.en_KCH = 1'b0;
        wait_idle();
        chk("busyign_chosen", 32'(bus.chosenCH), 70);
        chk("busyign_count",  32'(bus.ch_count), 1);

        @(negedge clk);
        bus.HB_reset = 1'b1; bus.HB_CHlimit = 0; bus.en_KCH = 1'b1;
        @(negedge clk);
        bus.HB_reset = 1'b0; bus.en_KCH = 1'b0;
        repeat (3) @(negedge clk);
        chk("hbins_count", 32'(bus.ch_count), 0);
        chk("hbins_valid", 32'(bus.ch_valid), 0);
        chk("hbins_busy",  32'(bus.busy), 0);

        for (int it = 0; it < 300; it++) begin
            @(negedge clk);
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 3))
                0:       qv = 16'h1000;
                1:       qv = 16'h2000;
                2:       qv = 16'h4000;
                default: qv = W'($urandom_range(0, 16'hFFFF));
            endcase
            bus.HB_reset   = (r < 4);
            bus.HB_CHlimit = W'($urandom_range(0, 6));
            bus.en_KCH     = (r >= 4 && r < 70) || (r >= 95);
            bus.en_drop    = (r >= 60);
            bus.fCH_ID     = W'($urandom_range(0, 7));
            bus.fCH_Hops   = W'($urandom_range(0, 3));
            bus.fCH_QValue = qv;
            bus.drop_ID    = W'($urandom_range(0, 7));
            @(negedge clk);
            bus.HB_reset = 1'b0; bus.en_KCH = 1'b0; bus.en_drop = 1'b0;
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        wait_idle();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/known_ch_table.md
Name: known_ch_table

Overview:
- Parametrised successor to the single-best cluster-head selector in the EER-RL node.
- Keeps a table of up to DEPTH known cluster heads (CHs): ID, hop count and Q-value, all from heartbeat/CH-advertisement packets.
- Supports refresh of existing entries, replacement of the worst entry, CH-limit enforcement and explicit CH drop.
- After every table change it rescans the table sequentially and atomically publishes the best CH to the routing/packet-build logic.

Parameters:
- WORD_WIDTH, 16, width of ID, hops and Q-value (Q-value is unsigned Q2.14, 16'h4000 = 1.00).
- DEPTH, 4, number of table entries (>=2).
- IDX_W, $clog2(DEPTH), entry index width (derived).

Ports:
- clk  in  1  system clock.
- nrst  in  1  synchronous, active-high reset (1 = reset).
- HB_reset  in  1  heartbeat received. Clears the table, latches HB_CHlimit, aborts any operation.
- HB_CHlimit  in  WORD_WIDTH  maximum number of CHs to retain. A value of 0 or >DEPTH means DEPTH.
- en_KCH  in  1  one-cycle strobe: insert/refresh CH using the fCH_* inputs.
- fCH_ID  in  WORD_WIDTH  advertised CH ID.
- fCH_Hops  in  WORD_WIDTH  hops to that CH.
- fCH_QValue  in  WORD_WIDTH  Q-value of that CH.
- en_drop  in  1  one-cycle strobe: remove the CH whose ID is drop_ID.
- drop_ID  in  WORD_WIDTH  ID to remove.
- chosenCH  out  WORD_WIDTH  best CH ID.
- hopsFromCH  out  WORD_WIDTH  hops of best CH.
- chosenQValue  out  WORD_WIDTH  Q-value of best CH.
- ch_valid  out  1  table non-empty; outputs are meaningful.
- ch_count  out  IDX_W+1  number of valid entries.
- table_full  out  1  ch_count == effective limit.
- busy  out  1  FSM not in IDLE; strobes are ignored while high.

Behaviour:
- Reset and HB_reset values:
  - chosenCH=0, hopsFromCH=16'hFFFF, chosenQValue=0, ch_valid=0, ch_count=0, busy=0, all valid bits cleared.
  - Reset also sets the latched limit to DEPTH.
  - HB_reset additionally latches HB_CHlimit.
  - Both take effect in one cycle, from any state; the FSM returns to IDLE.
- Priority in IDLE: nrst > HB_reset > en_KCH > en_drop. A lower-priority strobe in the same cycle is discarded.
- Ranking, better(a,b): the higher Q wins. If Q is equal, fewer hops wins. If both are equal, the lower ID wins. No two valid entries share an ID.
- FSM states: IDLE -> SEARCH -> WRITE -> SCAN -> COMMIT -> IDLE.
- SEARCH (DEPTH cycles, idx 0..DEPTH-1, one entry per cycle):
  - Records the matching-ID index.
  - Records the first free index.
  - Records the worst valid index (the entry every other entry beats).
- WRITE (1 cycle), insert:
  - ID match -> overwrite hops and Q in place.
  - Else if ch_count < limit -> write to the first free slot, ch_count+1.
  - Else, if the new entry beats the worst entry -> overwrite the worst slot.
  - Otherwise discard.
- WRITE (1 cycle), drop: if the ID matches, clear that valid bit, ch_count-1; otherwise no change.
- SCAN (DEPTH cycles): sequential best-of over valid entries.
- COMMIT (1 cycle):
  - Outputs are registered from the SCAN result.
  - If no valid entries: ch_valid=0, chosenCH=0, hopsFromCH=16'hFFFF, chosenQValue=0.
- Latency: a strobe sampled at edge 0 is reflected on the outputs after edge 2*DEPTH+2 (10 cycles for DEPTH=4). busy is high in between.
- Outputs stay stable while busy; they never show partial scan results.
- A limit below the current count cannot occur, because the limit only changes with a table clear.
- Arithmetic: comparisons are unsigned at full WORD_WIDTH. No saturation is needed.

Decomposition:
- Package knownch_pkg:
  - WORD_WIDTH default.
  - state enum (IDLE, SEARCH, WRITE, SCAN, COMMIT).
  - ch_entry_t struct {valid, id, hops, qvalue}.
  - HOPS_NONE = 16'hFFFF.
- Sub-module ch_compare: combinational better(a,b) per the ranking rule. It is instantiated once for the worst-tracking in SEARCH and once for the best-tracking in SCAN.

Test Plan:
1. Reset:
   - nrst=1 for 1 cycle -> chosenCH=0, hopsFromCH=FFFF, ch_valid=0, busy=0.
   - HB_reset mid-SCAN -> same values on the next cycle, busy=0.
2. Insert sequence (wait !busy between inserts):
   - 23/2/3000 -> chosen 23, hops 2.
   - 45/2/2000 -> still 23.
   - 12/1/4000 -> 12.
   - 6/1/4000 -> 6 (lower-ID tie).
   - 65/1/6000 -> table full, replaces 45, chosen 65, ch_count=4, table_full=1.
3. Refresh: 65/1/1000 -> entry updated in place, ch_count=4, chosen 6, hops 1, Q 4000.
4. Limit:
   - HB_reset with HB_CHlimit=2.
   - Insert 1/3/1000 and 2/3/2000 -> table_full=1.
   - Insert 3/3/1800 -> replaces ID 1.
   - Insert 4/3/0800 -> discarded; chosen 2, ch_count=2.
5. Drop:
   - From state 4, en_drop ID 2 -> chosen 3, ch_count=1.
   - Drop ID 3 -> ch_valid=0, hopsFromCH=FFFF.
   - Drop of absent ID 9 -> no change.
6. Timing and priority:
   - en_KCH at edge 0 -> outputs change exactly after edge 10 (DEPTH=4).
   - en_KCH while busy -> ignored.
   - en_KCH together with HB_reset -> table empty.
